// File: rtl/alu_multicycle_if.sv
// Request/response handshake bundle between the execute stage and the multi-cycle ALU.
interface alu_multicycle_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_in_1;
    logic [DATA_WIDTH-1:0] alu_in_2;
    logic [OP_WIDTH-1:0]   alu_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  bcond;
    logic                  busy;

    modport master (
        output in_valid, alu_in_1, alu_in_2, alu_op, out_ready,
        input  in_ready, out_valid, alu_result, bcond, busy
    );

    modport slave (
        input  in_valid, alu_in_1, alu_in_2, alu_op, out_ready,
        output in_ready, out_valid, alu_result, bcond, busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// RV32 execute-stage ALU: single-cycle integer/branch ops plus iterative
// M-extension multiply (shift-add) and divide (restoring), behind valid/ready.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_BEQ    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_BNE    = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_BLT    = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_BGE    = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_BLTU   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_BGEU   = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(21);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(22);
    localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(23);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     opnd;
    logic             is_div_q;
    logic             hi_q;
    logic             neg_q;
    logic [W-1:0]     result_q;
    logic             bcond_q;

    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic [SHAMT_W-1:0]   shamt;
    logic                 lt_s;
    logic                 lt_u;
    logic [W-1:0]         sc_result;
    logic                 sc_bcond;

    assign a     = bus.alu_in_1;
    assign b     = bus.alu_in_2;
    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sc_result = '0;
        sc_bcond  = 1'b0;
        case (bus.alu_op)
            OP_ADD:  sc_result = a + b;
            OP_SUB:  sc_result = a - b;
            OP_SLL:  sc_result = a << shamt;
            OP_XOR:  sc_result = a ^ b;
            OP_OR:   sc_result = a | b;
            OP_AND:  sc_result = a & b;
            OP_SRL:  sc_result = a >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  sc_result = {{(W-1){1'b0}}, lt_s};
            OP_SLTU: sc_result = {{(W-1){1'b0}}, lt_u};
            OP_BEQ:  sc_bcond  = (a == b);
            OP_BNE:  sc_bcond  = (a != b);
            OP_BLT:  sc_bcond  = lt_s;
            OP_BGE:  sc_bcond  = !lt_s;
            OP_BLTU: sc_bcond  = lt_u;
            OP_BGEU: sc_bcond  = !lt_u;
            default: ;
        endcase
    end

    logic         is_mul;
    logic         is_div;
    logic         a_signed;
    logic         b_signed;
    logic         want_hi;
    logic         a_neg;
    logic         b_neg;
    logic         div_zero;
    logic         div_ovf;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] early_result;

    assign is_mul   = bus.alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div   = bus.alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign a_signed = bus.alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = bus.alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    // High half of the product doubles as "remainder" for the divide family.
    assign want_hi  = bus.alu_op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    assign a_neg    = a_signed & a[W-1];
    assign b_neg    = b_signed & b[W-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = (bus.alu_op inside {OP_DIV, OP_REM}) && (a == MOST_NEG) && (b == '1);
    assign early_result = div_zero ? (want_hi ? a : '1) : (want_hi ? '0 : a);

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [2*W-1:0] step;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   div_half;
    logic [W-1:0]   final_result;

    // Multiply keeps {partial, multiplier} and shifts right; divide keeps
    // {remainder, quotient} and shifts left.
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    assign div_shift = acc[2*W-1:W-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[W-1:0] - opnd;
    assign step      = is_div_q
                     ? {(div_ge ? div_diff : div_shift[W-1:0]), acc[W-2:0], div_ge}
                     : (acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]});

    assign prod_fixed   = neg_q ? -step : step;
    assign div_half     = hi_q ? step[2*W-1:W] : step[W-1:0];
    assign final_result = is_div_q ? (neg_q ? -div_half : div_half)
                                   : (hi_q ? prod_fixed[2*W-1:W] : prod_fixed[W-1:0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            bcond_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mul || (is_div && !div_zero && !div_ovf)) begin
                            acc      <= is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                            opnd     <= is_div ? b_mag : a_mag;
                            is_div_q <= is_div;
                            hi_q     <= want_hi;
                            neg_q    <= (is_div && want_hi) ? a_neg : (a_neg ^ b_neg);
                            cnt      <= CNT_W'(W);
                            state    <= CALC;
                        end else begin
                            result_q <= is_div ? early_result : sc_result;
                            bcond_q  <= sc_bcond;
                            state    <= DONE;
                        end
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_q <= final_result;
                        bcond_q  <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state == CALC);
    assign bus.out_valid  = (state == DONE);
    assign bus.alu_result = result_q;
    assign bus.bcond      = bcond_q;
endmodule
